// File: rtl/alu_pkg.sv
// Shared opcode, flag-index and FSM definitions for the sequential microcontroller ALU.
package alu_pkg;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_ADC   = 4'd2;
  localparam logic [3:0] OP_SBB   = 4'd3;
  localparam logic [3:0] OP_AND   = 4'd4;
  localparam logic [3:0] OP_OR    = 4'd5;
  localparam logic [3:0] OP_XOR   = 4'd6;
  localparam logic [3:0] OP_NOT   = 4'd7;
  localparam logic [3:0] OP_SHL   = 4'd8;
  localparam logic [3:0] OP_SHR   = 4'd9;
  localparam logic [3:0] OP_SAR   = 4'd10;
  localparam logic [3:0] OP_INC   = 4'd11;
  localparam logic [3:0] OP_DEC   = 4'd12;
  localparam logic [3:0] OP_MUL   = 4'd13;
  localparam logic [3:0] OP_CMP   = 4'd14;
  localparam logic [3:0] OP_PASSB = 4'd15;

  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_C = 2;
  localparam int unsigned FLAG_S = 1;
  localparam int unsigned FLAG_O = 0;

  typedef enum logic [0:0] {
    StIdle,
    StMul
  } alu_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Unsigned shift-add multiplier: one partial product per cycle for WIDTH cycles.
module alu_mul_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned CntW = $clog2(WIDTH);

  logic                 run_q;
  logic [CntW-1:0]      cnt_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [2*WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]     mplier_q;
  logic [2*WIDTH-1:0]   acc_next;

  assign acc_next = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  // Final product is presented combinationally during the last iteration so the
  // caller can register it on the same edge the iteration completes.
  assign done    = run_q && (cnt_q == CntW'(WIDTH - 1));
  assign product = acc_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q    <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else if (start) begin
      run_q    <= 1'b1;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= {{WIDTH{1'b0}}, a};
      mplier_q <= b;
    end else if (run_q) begin
      acc_q    <= acc_next;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
      if (done) begin
        run_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshake, carry chaining and an optional
// multi-cycle multiply; result and ZCSO flags are held until the consumer drains them.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter bit          MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       mode,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             busy
);

  localparam int unsigned Msb = WIDTH - 1;

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flags_q, flags_d;
  logic             out_valid_q, out_valid_d;
  logic             carry_q;

  logic             accept;
  logic             is_mul;
  logic             mul_start;
  logic             mul_done;
  logic [2*WIDTH-1:0] mul_product;

  // Shared adder/subtractor for the add/sub family, INC, DEC and CMP.
  logic [WIDTH-1:0] arith_b;
  logic             arith_cin;
  logic             arith_sub;
  logic [WIDTH:0]   cin_ext;
  logic [WIDTH:0]   arith_sum;
  logic [WIDTH-1:0] arith_res;
  logic             arith_ovf;

  logic [WIDTH-1:0] op_res;
  logic             op_c;
  logic             op_o;
  logic [WIDTH-1:0] flag_val;
  logic [3:0]       op_flags;

  logic [WIDTH-1:0] mul_lo;
  logic             mul_hi_nz;
  logic [3:0]       mul_flags;

  assign carry_q   = flags_q[FLAG_C];
  assign in_ready  = (state_q == StIdle) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign is_mul    = MUL_EN && (mode == OP_MUL);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;
  assign busy      = (state_q == StMul);

  always_comb begin
    arith_b   = op_b;
    arith_cin = 1'b0;
    arith_sub = 1'b0;
    case (mode)
      OP_SUB, OP_CMP: arith_sub = 1'b1;
      OP_ADC:         arith_cin = carry_q;
      OP_SBB: begin
        arith_sub = 1'b1;
        arith_cin = carry_q;
      end
      OP_INC:         arith_b = WIDTH'(1);
      OP_DEC: begin
        arith_sub = 1'b1;
        arith_b   = WIDTH'(1);
      end
      default: ;
    endcase
  end

  assign cin_ext   = {{WIDTH{1'b0}}, arith_cin};
  // In WIDTH+1 bits, bit WIDTH is carry-out for adds and the borrow for subtracts.
  assign arith_sum = arith_sub ? ({1'b0, op_a} - {1'b0, arith_b} - cin_ext)
                               : ({1'b0, op_a} + {1'b0, arith_b} + cin_ext);
  assign arith_res = arith_sum[WIDTH-1:0];
  assign arith_ovf = arith_sub
      ? ((op_a[Msb] != arith_b[Msb]) && (arith_res[Msb] != op_a[Msb]))
      : ((op_a[Msb] == arith_b[Msb]) && (arith_res[Msb] != op_a[Msb]));

  always_comb begin
    op_res = arith_res;
    op_c   = arith_sum[WIDTH];
    op_o   = arith_ovf;
    case (mode)
      OP_AND: begin
        op_res = op_a & op_b;
        op_c   = 1'b0;
        op_o   = 1'b0;
      end
      OP_OR: begin
        op_res = op_a | op_b;
        op_c   = 1'b0;
        op_o   = 1'b0;
      end
      OP_XOR: begin
        op_res = op_a ^ op_b;
        op_c   = 1'b0;
        op_o   = 1'b0;
      end
      OP_NOT: begin
        op_res = ~op_a;
        op_c   = 1'b0;
        op_o   = 1'b0;
      end
      OP_SHL: begin
        op_res = {op_a[Msb-1:0], 1'b0};
        op_c   = op_a[Msb];
        op_o   = op_a[Msb] ^ op_a[Msb-1];
      end
      OP_SHR: begin
        op_res = {1'b0, op_a[Msb:1]};
        op_c   = op_a[0];
        op_o   = 1'b0;
      end
      OP_SAR: begin
        op_res = {op_a[Msb], op_a[Msb:1]};
        op_c   = op_a[0];
        op_o   = 1'b0;
      end
      OP_CMP:  op_res = op_a;
      // MUL only lands here when the multiplier is not built.
      OP_MUL, OP_PASSB: begin
        op_res = op_b;
        op_c   = 1'b0;
        op_o   = 1'b0;
      end
      default: ;
    endcase
  end

  assign flag_val = (mode == OP_CMP) ? arith_res : op_res;
  assign op_flags = {(flag_val == '0), op_c, flag_val[Msb], op_o};

  assign mul_lo    = mul_product[WIDTH-1:0];
  assign mul_hi_nz = |mul_product[2*WIDTH-1:WIDTH];
  assign mul_flags = {(mul_lo == '0), mul_hi_nz, mul_lo[Msb], mul_hi_nz};

  if (MUL_EN) begin : g_mul
    alu_mul_seq #(
      .WIDTH (WIDTH)
    ) u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (mul_start),
      .a       (op_a),
      .b       (op_b),
      .done    (mul_done),
      .product (mul_product)
    );
  end else begin : g_no_mul
    assign mul_done    = 1'b0;
    assign mul_product = '0;
  end

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    flags_d     = flags_q;
    out_valid_d = out_valid_q && !out_ready;
    mul_start   = 1'b0;
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (is_mul) begin
            state_d   = StMul;
            mul_start = 1'b1;
          end else begin
            result_d    = op_res;
            flags_d     = op_flags;
            out_valid_d = 1'b1;
          end
        end
      end
      StMul: begin
        if (mul_done) begin
          state_d     = StIdle;
          result_d    = mul_lo;
          flags_d     = mul_flags;
          out_valid_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      result_q    <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8): directed vector table, randomized ops
// against an arithmetic reference model, and backpressure / reset-abort sequences.
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] mode = '0;
  logic [7:0] op_a = '0;
  logic [7:0] op_b = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] result;
  logic [3:0] flags;
  logic       busy;

  int tests = 0;
  int failed = 0;
  int model_c = 0;

  alu_seq #(
    .WIDTH  (8),
    .MUL_EN (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] m;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] r;
    logic [3:0] f;
    int         lat;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic int to_s8(input int v);
    return (v > 127) ? v - 256 : v;
  endfunction

  // Returns {result[7:0], flags[3:0]} from the arithmetic meaning of each opcode.
  function automatic logic [11:0] ref_op(input int m, input int ua, input int ub, input int cin);
    int sa, sb, r, fv, p;
    bit c, o;
    sa = to_s8(ua);
    sb = to_s8(ub);
    c = 0;
    o = 0;
    r = 0;
    fv = -1;
    case (m)
      0:  begin r = ua + ub; c = r > 255; o = (sa + sb > 127) || (sa + sb < -128); end
      1:  begin r = ua - ub; c = ua < ub; o = (sa - sb > 127) || (sa - sb < -128); end
      2:  begin
            r = ua + ub + cin; c = r > 255;
            o = (sa + sb + cin > 127) || (sa + sb + cin < -128);
          end
      3:  begin
            r = ua - ub - cin; c = ua < ub + cin;
            o = (sa - sb - cin > 127) || (sa - sb - cin < -128);
          end
      4:  r = ua & ub;
      5:  r = ua | ub;
      6:  r = ua ^ ub;
      7:  r = 255 - ua;
      8:  begin r = ua * 2; c = ua >= 128; o = (sa * 2 > 127) || (sa * 2 < -128); end
      9:  begin r = ua / 2; c = ua % 2; end
      10: begin r = sa >>> 1; c = ua % 2; end
      11: begin r = ua + 1; c = r > 255; o = sa == 127; end
      12: begin r = ua - 1; c = ua < 1; o = sa == -128; end
      13: begin p = ua * ub; r = p; c = p > 255; o = c; end
      14: begin
            r = ua; fv = (ua - ub) & 255; c = ua < ub;
            o = (sa - sb > 127) || (sa - sb < -128);
          end
      default: r = ub;
    endcase
    r = r & 255;
    if (fv < 0) fv = r;
    return {r[7:0], (fv == 0), c, fv[7], o};
  endfunction

  task automatic do_op(input logic [3:0] m, input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] r, output logic [3:0] f, output int lat,
                       output int hold_err);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    mode = m; op_a = a; op_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    hold_err = 0;
    while (!out_valid && lat < 50) begin
      if (!busy || in_ready) hold_err++;
      @(posedge clk); #1;
      lat++;
    end
    r = result;
    f = flags;
    @(posedge clk); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  r;
    logic [3:0]  f;
    logic [11:0] exp;
    int lat, herr, stable, rdy_bad, early;

    vecs[0] = '{4'd0,  8'h01, 8'h02, 8'h03, 4'b0000, 1};
    vecs[1] = '{4'd0,  8'h7F, 8'h01, 8'h80, 4'b0011, 1};
    vecs[2] = '{4'd0,  8'hFF, 8'h80, 8'h7F, 4'b0101, 1};
    vecs[3] = '{4'd0,  8'h7E, 8'h82, 8'h00, 4'b1100, 1};
    vecs[4] = '{4'd0,  8'hFF, 8'h01, 8'h00, 4'b1100, 1};
    vecs[5] = '{4'd2,  8'h00, 8'h00, 8'h01, 4'b0000, 1};
    vecs[6] = '{4'd1,  8'h00, 8'h01, 8'hFF, 4'b0110, 1};
    vecs[7] = '{4'd13, 8'h0C, 8'h0B, 8'h84, 4'b0010, 9};
    vecs[8] = '{4'd13, 8'h10, 8'h10, 8'h00, 4'b1101, 9};
    vecs[9] = '{4'd14, 8'h05, 8'h07, 8'h05, 4'b0110, 1};

    // Reset state
    #2;
    check("reset_result", result, 0);
    check("reset_flags", flags, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_busy", busy, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("ready_after_reset", in_ready, 1);

    // Directed table
    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i].m, vecs[i].a, vecs[i].b, r, f, lat, herr);
      check($sformatf("vec%0d_result", i), r, vecs[i].r);
      check($sformatf("vec%0d_flags", i), f, vecs[i].f);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      if (vecs[i].lat > 1) check($sformatf("vec%0d_busy_hold", i), herr, 0);
      model_c = vecs[i].f[2];
    end

    // Randomized ops vs. reference model; carry threads through the sequence
    for (int i = 0; i < 200; i++) begin
      logic [3:0] m;
      logic [7:0] a, b;
      m = 4'($urandom_range(0, 15));
      a = 8'($urandom);
      b = 8'($urandom);
      if (i % 7 == 0) b = 8'(a + 1);
      exp = ref_op(int'(m), int'(a), int'(b), model_c);
      do_op(m, a, b, r, f, lat, herr);
      check($sformatf("rand%0d_m%0d_a%0h_b%0h", i, m, a, b), {r, f}, exp);
      check($sformatf("rand%0d_latency", i), lat, (m == 4'd13) ? 9 : 1);
      model_c = exp[2];
    end

    // Backpressure: hold result for 5 cycles, then drain and accept in one cycle
    out_ready = 1'b0;
    mode = 4'd0; op_a = 8'd3; op_b = 8'd4; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_first_valid", out_valid, 1);
    check("bp_first_result", result, 7);
    stable = 1;
    rdy_bad = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (result != 8'd7 || !out_valid) stable = 0;
      if (in_ready) rdy_bad++;
    end
    check("bp_hold_stable", stable, 1);
    check("bp_hold_not_ready", rdy_bad, 0);
    mode = 4'd0; op_a = 8'd10; op_b = 8'd20; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check("bp_ready_on_drain", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_b2b_valid", out_valid, 1);
    check("bp_b2b_result", result, 30);
    check("bp_b2b_flags", flags, 0);
    @(posedge clk); #1;
    check("bp_drained", out_valid, 0);

    // Reset during cycle 4 of a multiply aborts it with no output
    mode = 4'd13; op_a = 8'd12; op_b = 8'd11; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_busy_before", busy, 1);
    rst = 1'b1;
    #1;
    check("abort_result", result, 0);
    check("abort_flags", flags, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    early = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid || busy) early++;
    end
    check("abort_no_output", early, 0);
    do_op(4'd14, 8'd5, 8'd7, r, f, lat, herr);
    check("post_abort_cmp_result", r, 5);
    check("post_abort_cmp_flags", f, 4'b0110);
    check("post_abort_cmp_latency", lat, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
